irq_ctrl: RTL
=============

# irq_ctrl

Seven-source interrupt controller between on-board interrupt sources (ACIA `irq_n`, timers, buttons) and the fx68k `IPL2n..IPL0n` inputs. Synchronises and latches requests, applies per-source enable and edge/level mode, and drives the priority-encoded IPL. It also recognises the CPU interrupt-acknowledge cycle and answers it with an autovector (`VPAn`) or, optionally, a programmed vector.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each `irq_in` bit (minimum 2).
- `clk` in 1: system clock (25 MHz).
- `rst_n` in 1: synchronous, active-low reset.
- `irq_in` in 7: asynchronous requests, active high; bit i maps to level i+1.
- `cs` in 1: register select (peripheral window, VMA-qualified).
- `rw_n` in 1: 1 = read, 0 = write.
- `rs` in 2: register select (CPU `addr[2:1]`).
- `data_in` in 8: write data (CPU `dout[7:0]`).
- `data_out` out 8: read data; during an acknowledge with vectoring active, the vector number.
- `as_n` in 1: CPU address strobe.
- `fc` in 3: CPU function code.
- `iack_addr` in 3: CPU `addr[3:1]`, the level being acknowledged.
- `ipl_n` out 3: encoded priority to CPU, active low.
- `vpa_n` out 1: autovector request, active low.
- `iack_dtack_n` out 1: vectored-acknowledge DTACK, active low (held 1 without `IRQ_CTRL_VECTOR_EN`).

## Operation
- Registers (`rs`):
  - 0 PEND: read pending[6:0]; write 1 clears that bit, write 0 has no effect.
  - 1 ENABLE: R/W mask, 1 = enabled.
  - 2 MODE: R/W, 1 = edge (rising), 0 = level.
  - 3 STATUS: read {`iack_busy`, 4'b0, `cur_level`[2:0]}; VECBASE when vectoring is compiled in (see Configuration).
- Bit 7 reads 0 in PEND, ENABLE and MODE.
- Writes act once per access, on the first cycle `cs && !rw_n` rises, because the CPU holds `cs` for several cycles.
- Pending, per source: level mode follows the synchronised input. Edge mode sets on a synchronised 0→1 and holds until a W1C write or acknowledge.
- Active = pending & enable. `cur_level` = index of highest active bit + 1, or 0 if none. `ipl_n` = ~`cur_level`, registered.
- Acknowledge cycle: `fc == 3'b111 && !as_n`.
  - On entry (first cycle), `iack_busy` sets and `ack_level` latches `iack_addr`.
  - If `ack_level` is active and in edge mode, its pending bit clears once on entry.
  - `vpa_n` = 0 for the whole cycle (autovector) while `as_n` is low. It returns to 1 the cycle after `as_n` rises, and `iack_busy` clears at the same time.
  - Acknowledge of a level that is not active (spurious): still autovectored, no state change.
- Simultaneous events: a new edge set in the same cycle as a W1C or acknowledge clear leaves the bit set. Write to ENABLE/MODE in the same cycle as an edge: the edge is still captured.
- Level-mode bits ignore W1C and acknowledge clears.

## Timing
- Reset (`rst_n` low at a `clk` edge): pending, ENABLE, MODE = 0; `ipl_n` = 3'b111; `vpa_n` = 1; `iack_dtack_n` = 1; `iack_busy` = 0; sync chains = 0; `data_out` = 0.
- Reset mid-acknowledge forces `vpa_n` = 1 next cycle.
- `irq_in` rising edge → `ipl_n` change: SYNC_STAGES + 2 cycles (4 at default).
- Register write → effect on `ipl_n`: 2 cycles after the write-strobe rise.
- `data_out` is registered: read data is valid 1 cycle after `cs` with `rw_n` = 1; it holds 0 when not selected.
- `vpa_n` asserts 1 cycle after acknowledge entry.

## Configuration
- `IRQ_CTRL_VECTOR_EN` defined:
  - `rs` = 3 write sets VECBASE[7:3]; VECBASE reset value 8'h40.
  - Acknowledge of an active level drives `data_out` = {VECBASE[7:3], `ack_level`} and `iack_dtack_n` = 0 from 1 cycle after entry until `as_n` rises; `vpa_n` stays 1.
  - Spurious acknowledge still autovectors.
- Not defined: no VECBASE; `rs` = 3 is read-only STATUS; `iack_dtack_n` is tied 1; all acknowledges autovector.

## Structure
- Package `irq_ctrl_pkg`: register offsets (PEND, ENABLE, MODE, STATUS), NUM_SRC = 7, FC_IACK = 3'b111, VECBASE reset constant.
- One sub-module, `irq_sync_edge`: per-bit SYNC_STAGES synchroniser plus rising-edge detector, instantiated once with 7-bit width.

## Test plan
- Reset, then ENABLE = 8'h7F, MODE = 0, hold `irq_in` = 7'b000_0100 → `ipl_n` = 3'b100 (level 3) after 4 cycles; drop input → `ipl_n` = 3'b111.
- MODE = 8'h7F, pulse `irq_in[0]` 1 cycle, then `irq_in[4]` → `ipl_n` = ~5; W1C PEND with 8'h10 → `ipl_n` = ~1; W1C 8'h01 → 3'b111.
- ENABLE = 0 with `irq_in` = 7'h7F → `ipl_n` stays 3'b111; PEND reads 8'h7F in level mode.
- Edge source 6 pending, acknowledge with `fc` = 7, `iack_addr` = 6 → `vpa_n` = 0 next cycle, PEND bit 5 cleared, `vpa_n` = 1 one cycle after `as_n` rises.
- Edge on `irq_in[2]` in the same cycle as a W1C of bit 2 → PEND bit 2 remains 1.
- `IRQ_CTRL_VECTOR_EN`, VECBASE = 8'h80, acknowledge level 2 → `data_out` = 8'h82, `iack_dtack_n` = 0, `vpa_n` = 1.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants and helpers for the seven-source interrupt
// controller.
//   reg_sel_e        register offsets addressed by rs (CPU addr[2:1])
//   NUM_SRC          number of interrupt sources (levels 1..7)
//   FC_IACK          function code of the 68000 interrupt-acknowledge cycle
//   VECBASE_RST      reset value of the vector base (vectoring builds only)
//   prio_level()     highest active source index + 1, 0 when none
//   level_onehot()   IPL level -> source bit, level 0 maps to no bit
package irq_ctrl_pkg;

  localparam int NUM_SRC = 7;

  typedef enum logic [1:0] {
    REG_PEND   = 2'd0,
    REG_ENABLE = 2'd1,
    REG_MODE   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam logic [2:0] FC_IACK     = 3'b111;
  localparam logic [7:0] VECBASE_RST = 8'h40;

  function automatic logic [2:0] prio_level(input logic [NUM_SRC-1:0] act);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < NUM_SRC; i++)
      if (act[i]) lvl = 3'(i + 1);
    return lvl;
  endfunction

  function automatic logic [NUM_SRC-1:0] level_onehot(input logic [2:0] lvl);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (lvl == 3'(i + 1)) oh[i] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-bit multi-stage synchroniser with rising-edge detect.
//   clk       system clock
//   rst_n     synchronous active-low reset (clears chains and edge history)
//   d_in      asynchronous inputs
//   sync_out  synchronised level (last chain stage)
//   rise      one-cycle pulse on a synchronised 0->1 transition
// STAGES below 2 is clamped to 2; a single flop is not a synchroniser.
module irq_sync_edge #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N-1:0] sh;
    logic         prev;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sh   <= '0;
        prev <= 1'b0;
      end else begin
        sh   <= {sh[N-2:0], d_in[b]};
        prev <= sh[N-1];
      end
    end

    assign sync_out[b] = sh[N-1];
    assign rise[b]     = sh[N-1] & ~prev;
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: seven-source interrupt controller for the fx68k IPL inputs.
//   clk, rst_n          25 MHz clock, synchronous active-low reset
//   irq_in[6:0]         async requests, bit i -> level i+1
//   cs, rw_n, rs, data_in, data_out   register port (PEND/ENABLE/MODE/STATUS)
//   as_n, fc, iack_addr CPU bus signals used to spot interrupt acknowledge
//   ipl_n               registered, active-low encoded priority
//   vpa_n               autovector request during acknowledge
//   iack_dtack_n        DTACK for a vectored acknowledge
// Build option: define IRQ_CTRL_VECTOR_EN to add a programmable VECBASE
// (write/read at rs=3) and answer acknowledges of active levels with a vector
// number instead of an autovector. Without it iack_dtack_n is tied high.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cs,
  input  logic               rw_n,
  input  logic [1:0]         rs,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  input  logic               as_n,
  input  logic [2:0]         fc,
  input  logic [2:0]         iack_addr,
  output logic [2:0]         ipl_n,
  output logic               vpa_n,
  output logic               iack_dtack_n
);

  logic [NUM_SRC-1:0] sync_lvl, rise;
  logic [NUM_SRC-1:0] pending, enable, mode, active;
  logic [NUM_SRC-1:0] w1c, ack_hit, ack_clr, pend_nxt;
  logic [2:0]         cur_level;
  logic               wr_q, wr_stb;
  logic               iack, iack_busy, iack_entry;
  logic [7:0]         rdata;

  irq_sync_edge #(.WIDTH(NUM_SRC), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (irq_in),
    .sync_out(sync_lvl),
    .rise    (rise)
  );

  // CPU holds cs across several clocks; act only on the first write cycle.
  assign wr_stb = cs & ~rw_n & ~wr_q;

  assign active    = pending & enable;
  assign cur_level = prio_level(active);

  assign iack       = (fc == FC_IACK) & ~as_n;
  assign iack_entry = iack & ~iack_busy;
  // Decoded straight from iack_addr so the clear lands on the entry edge.
  assign ack_hit    = level_onehot(iack_addr) & active;
  assign ack_clr    = iack_entry ? (ack_hit & mode) : '0;
  assign w1c        = (wr_stb && rs == REG_PEND) ? data_in[NUM_SRC-1:0] : '0;

  // Edge bits: a fresh rise wins over any clear in the same cycle.
  // Level bits simply track the synchronised input and ignore clears.
  assign pend_nxt = (mode & (rise | (pending & ~(w1c | ack_clr)))) |
                    (~mode & sync_lvl);

`ifdef IRQ_CTRL_VECTOR_EN
  logic [4:0] vecbase_hi;
  logic [2:0] ack_level;
  logic       ack_vec, dtack_q, vec_drive;
  logic [2:0] vec_lvl;

  assign iack_dtack_n = dtack_q;
  assign vec_drive    = (iack_entry && |ack_hit) || (ack_vec && iack);
  assign vec_lvl      = iack_entry ? iack_addr : ack_level;
`else
  logic unused_data;
  assign unused_data  = data_in[7];
  assign iack_dtack_n = 1'b1;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel_e'(rs))
      REG_PEND:   rdata = {1'b0, pending};
      REG_ENABLE: rdata = {1'b0, enable};
      REG_MODE:   rdata = {1'b0, mode};
`ifdef IRQ_CTRL_VECTOR_EN
      REG_STATUS: rdata = {vecbase_hi, 3'b000};
`else
      REG_STATUS: rdata = {iack_busy, 4'b0000, cur_level};
`endif
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      enable    <= '0;
      mode      <= '0;
      ipl_n     <= 3'b111;
      wr_q      <= 1'b0;
      iack_busy <= 1'b0;
      vpa_n     <= 1'b1;
      data_out  <= '0;
`ifdef IRQ_CTRL_VECTOR_EN
      vecbase_hi <= VECBASE_RST[7:3];
      ack_level  <= '0;
      ack_vec    <= 1'b0;
      dtack_q    <= 1'b1;
`endif
    end else begin
      pending <= pend_nxt;
      ipl_n   <= ~cur_level;
      wr_q    <= cs & ~rw_n;

      if (wr_stb) begin
        case (reg_sel_e'(rs))
          REG_ENABLE: enable <= data_in[NUM_SRC-1:0];
          REG_MODE:   mode   <= data_in[NUM_SRC-1:0];
`ifdef IRQ_CTRL_VECTOR_EN
          REG_STATUS: vecbase_hi <= data_in[7:3];
`endif
          default: ;
        endcase
      end

      if (iack_entry) begin
        iack_busy <= 1'b1;
`ifdef IRQ_CTRL_VECTOR_EN
        ack_level <= iack_addr;
        ack_vec   <= |ack_hit;
        dtack_q   <= ~|ack_hit;
        vpa_n     <= ~|ack_hit;   // spurious acknowledges still autovector
`else
        vpa_n     <= 1'b0;
`endif
      end else if (iack_busy && !iack) begin
        iack_busy <= 1'b0;
        vpa_n     <= 1'b1;
`ifdef IRQ_CTRL_VECTOR_EN
        ack_vec   <= 1'b0;
        dtack_q   <= 1'b1;
`endif
      end

`ifdef IRQ_CTRL_VECTOR_EN
      if (vec_drive)
        data_out <= {vecbase_hi, vec_lvl};
      else
`endif
        data_out <= (cs && rw_n) ? rdata : 8'h00;
    end
  end

endmodule
